// File: rtl/defender_pkg.sv
// Shared constants and state encoding for the enemy shot collider.
package defender_pkg;

   localparam int unsigned NUM_SHOTS     = 5;
   localparam int unsigned SLOT_W        = 9;
   localparam int unsigned X_BUS_W       = 46;
   localparam int unsigned Y_BUS_W       = 45;
   localparam int unsigned X4_OFF        = 36;
   localparam int unsigned X4_W          = 10;
   localparam int unsigned CMP_W         = 11;
   localparam int unsigned COORD_W       = 10;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned LIVES_W       = 3;
   localparam int unsigned START_LIVES   = 3;
   localparam int unsigned HIT_HALF_W    = 10;
   localparam int unsigned SHIP_H        = 20;
   localparam int unsigned INVULN_CYCLES = 4095;
   localparam int unsigned CNT_W         = 12;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PLAY      = 2'd1,
      ST_COOLDOWN  = 2'd2,
      ST_GAME_OVER = 2'd3
   } collider_state_t;

endpackage

// File: rtl/ship_hitbox_cmp.sv
// Combinational test of one projectile against the player ship hit box.
module ship_hitbox_cmp
   import defender_pkg::*;
(
   input  logic [CMP_W-1:0] shot_x,
   input  logic [CMP_W-1:0] shot_y,
   input  logic [CMP_W-1:0] ship_x,
   input  logic [CMP_W-1:0] ship_y,
   output logic             in_box_c
);

   logic [CMP_W-1:0] dx;
   logic [CMP_W-1:0] ship_bottom;

   // Absolute distance by compare-and-subtract; 11 bits leaves headroom so nothing wraps.
   always_comb begin
      dx          = (shot_x >= ship_x) ? (shot_x - ship_x) : (ship_x - shot_x);
      ship_bottom = ship_y + CMP_W'(SHIP_H);
      in_box_c    = (dx < CMP_W'(HIT_HALF_W)) && (shot_y >= ship_y) && (shot_y < ship_bottom);
   end

endmodule

// File: rtl/enemy_shot_collider.sv
// Enemy shot vs player ship collider: scans one projectile slot per tick, raises
// per-slot destroy requests, and owns lives, invulnerability and game-over.
// Optional feature macro: SHIELD_EN adds a shield input that absorbs PLAY hits.
module enemy_shot_collider
   import defender_pkg::*;
(
   input  logic                 clk_4,
   input  logic                 clr,
   input  logic                 play,
   input  logic [X_BUS_W-1:0]   enemy_projectiles_x,
   input  logic [Y_BUS_W-1:0]   enemy_projectiles_y,
   input  logic [COORD_W-1:0]   ship_x,
   input  logic [COORD_W-1:0]   ship_y,
`ifdef SHIELD_EN
   input  logic                 shield,
`endif
   output logic [NUM_SHOTS-1:0] destroy,
   output logic                 player_hit,
   output logic [LIVES_W-1:0]   lives,
   output logic                 invuln,
   output logic                 game_over
);

   collider_state_t     state, state_next;
   logic [IDX_W-1:0]    idx, idx_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [NUM_SHOTS-1:0] destroy_d, y_active_c, hit_mask_c;
   logic [LIVES_W-1:0]  lives_d;
   logic                player_hit_d, invuln_d, game_over_d;
   logic [CMP_W-1:0]    sel_x_c, sel_y_c;
   logic                sel_destroyed_c, in_box_c;
   logic                scanning_c, hit_c, life_hit_c, shielded_c;

`ifdef SHIELD_EN
   assign shielded_c = shield;
`else
   assign shielded_c = 1'b0;
`endif

   // Scan mux: pick the indexed slot's coordinates and its pending destroy bit.
   always_comb begin
      sel_x_c         = '0;
      sel_y_c         = '0;
      sel_destroyed_c = 1'b0;
      case (idx)
         3'd0: begin sel_x_c = CMP_W'(enemy_projectiles_x[8:0]);   sel_y_c = CMP_W'(enemy_projectiles_y[8:0]);   sel_destroyed_c = destroy[0]; end
         3'd1: begin sel_x_c = CMP_W'(enemy_projectiles_x[17:9]);  sel_y_c = CMP_W'(enemy_projectiles_y[17:9]);  sel_destroyed_c = destroy[1]; end
         3'd2: begin sel_x_c = CMP_W'(enemy_projectiles_x[26:18]); sel_y_c = CMP_W'(enemy_projectiles_y[26:18]); sel_destroyed_c = destroy[2]; end
         3'd3: begin sel_x_c = CMP_W'(enemy_projectiles_x[35:27]); sel_y_c = CMP_W'(enemy_projectiles_y[35:27]); sel_destroyed_c = destroy[3]; end
         3'd4: begin sel_x_c = CMP_W'(enemy_projectiles_x[X4_OFF +: X4_W]); sel_y_c = CMP_W'(enemy_projectiles_y[44:36]); sel_destroyed_c = destroy[4]; end
         default: ;
      endcase
   end

   ship_hitbox_cmp u_hitbox (
      .shot_x   (sel_x_c),
      .shot_y   (sel_y_c),
      .ship_x   (CMP_W'(ship_x)),
      .ship_y   (CMP_W'(ship_y)),
      .in_box_c (in_box_c)
   );

   // Hit qualification: active slot, not already retiring, scanning states only.
   always_comb begin
      scanning_c = play && ((state == ST_PLAY) || (state == ST_COOLDOWN));
      hit_c      = scanning_c && (sel_y_c != '0) && !sel_destroyed_c && in_box_c;
      life_hit_c = hit_c && (state == ST_PLAY) && !shielded_c;
      hit_mask_c = hit_c ? (NUM_SHOTS'(1) << idx) : '0;
      for (int i = 0; i < NUM_SHOTS; i++)
         y_active_c[i] = (enemy_projectiles_y[SLOT_W*i +: SLOT_W] != '0);
   end

   // State register.
   always_ff @(posedge clk_4 or posedge clr) begin
      if (clr) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; dropping play always returns to IDLE.
   always_comb begin
      state_next = state;
      if (!play) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      state_next = ST_PLAY;
            ST_PLAY:      if (life_hit_c)
                             state_next = (lives == LIVES_W'(1)) ? ST_GAME_OVER : ST_COOLDOWN;
            ST_COOLDOWN:  if (cnt == '0) state_next = ST_PLAY;
            ST_GAME_OVER: state_next = ST_GAME_OVER;
            default:      state_next = ST_IDLE;
         endcase
      end
   end

   // Output/datapath next values.
   always_comb begin
      idx_d        = idx;
      cnt_d        = cnt;
      lives_d      = lives;
      destroy_d    = (destroy | hit_mask_c) & y_active_c;
      player_hit_d = life_hit_c;
      invuln_d     = (state_next == ST_COOLDOWN);
      game_over_d  = (state_next == ST_GAME_OVER);
      if (scanning_c)
         idx_d = (idx == IDX_W'(NUM_SHOTS - 1)) ? '0 : idx + IDX_W'(1);
      if (!play)
         cnt_d = '0;
      else if (life_hit_c)
         cnt_d = CNT_W'(INVULN_CYCLES);
      else if ((state == ST_COOLDOWN) && (cnt != '0))
         cnt_d = cnt - CNT_W'(1);
      if ((state == ST_IDLE) || (state_next == ST_IDLE))
         lives_d = LIVES_W'(START_LIVES);
      else if (life_hit_c)
         lives_d = lives - LIVES_W'(1);
      if (!play || (state == ST_IDLE))
         destroy_d = '0;
   end

   // Registered outputs, scan index and cooldown counter.
   always_ff @(posedge clk_4 or posedge clr) begin
      if (clr) begin
         idx        <= '0;
         cnt        <= '0;
         destroy    <= '0;
         player_hit <= 1'b0;
         lives      <= LIVES_W'(START_LIVES);
         invuln     <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         idx        <= idx_d;
         cnt        <= cnt_d;
         destroy    <= destroy_d;
         player_hit <= player_hit_d;
         lives      <= lives_d;
         invuln     <= invuln_d;
         game_over  <= game_over_d;
      end
   end

endmodule

// File: tb/tb_enemy_shot_collider.sv
// Directed bench for enemy_shot_collider; exercises the SHIELD_EN path when defined.
module tb_enemy_shot_collider;

   logic        clk_4 = 1'b0;
   logic        clr;
   logic        play;
   logic [45:0] px;
   logic [44:0] py;
   logic [9:0]  ship_x, ship_y;
   logic [4:0]  destroy;
   logic        player_hit, invuln, game_over;
   logic [2:0]  lives;
`ifdef SHIELD_EN
   logic        shield;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int lat, pulses;

   always #5 clk_4 = ~clk_4;

   enemy_shot_collider dut (
      .clk_4               (clk_4),
      .clr                 (clr),
      .play                (play),
      .enemy_projectiles_x (px),
      .enemy_projectiles_y (py),
      .ship_x              (ship_x),
      .ship_y              (ship_y),
`ifdef SHIELD_EN
      .shield              (shield),
`endif
      .destroy             (destroy),
      .player_hit          (player_hit),
      .lives               (lives),
      .invuln              (invuln),
      .game_over           (game_over)
   );

   // Single comparison point.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic set_shot(input int s, input int x, input int y);
      logic [9:0] xv;
      xv = 10'(x);
      if (s == 4) px[45:36] = xv;
      else        px[9*s +: 9] = xv[8:0];
      py[9*s +: 9] = 9'(y);
   endtask

   // Watch a slot for max cycles: first cycle destroy[s] seen, and player_hit pulses.
   task automatic watch(input int s, input int max, output int first, output int npulse);
      first  = -1;
      npulse = 0;
      for (int k = 1; k <= max; k++) begin
         @(negedge clk_4);
         if (player_hit) npulse++;
         if (destroy[s] && first < 0) first = k;
      end
   endtask

   task automatic wait_cooldown_end();
      for (int k = 0; k < 5000 && invuln; k++) @(negedge clk_4);
      chk("cooldown_end", 32'(invuln), 0);
   endtask

   initial begin
      clr = 1'b1; play = 1'b0; px = '0; py = '0;
      ship_x = 10'd200; ship_y = 10'd440;
`ifdef SHIELD_EN
      shield = 1'b0;
`endif
      repeat (2) @(negedge clk_4);
      chk("rst_lives", 32'(lives), 3);
      chk("rst_destroy", 32'(destroy), 0);
      chk("rst_invuln", 32'(invuln), 0);
      chk("rst_game_over", 32'(game_over), 0);
      chk("rst_player_hit", 32'(player_hit), 0);
      clr = 1'b0;
      play = 1'b1;
      repeat (2) @(negedge clk_4);

      // First hit on slot 2.
      set_shot(2, 205, 445);
      watch(2, 8, lat, pulses);
      chk("hit2_latency_ok", 32'(lat >= 1 && lat <= 6), 1);
      chk("hit2_pulses", 32'(pulses), 1);
      chk("hit2_lives", 32'(lives), 2);
      chk("hit2_invuln", 32'(invuln), 1);
      chk("hit2_destroy_held", 32'(destroy[2]), 1);
      set_shot(2, 0, 0);
      @(negedge clk_4);
      chk("clear2", 32'(destroy[2]), 0);

      // Hit during cooldown: retire only.
      set_shot(0, 195, 450);
      watch(0, 8, lat, pulses);
      chk("cd_hit_latency_ok", 32'(lat >= 1 && lat <= 6), 1);
      chk("cd_hit_pulses", 32'(pulses), 0);
      chk("cd_hit_lives", 32'(lives), 2);
      set_shot(0, 0, 0);
      @(negedge clk_4);

      // Window edges on slot 1.
      set_shot(1, 210, 450);
      watch(1, 12, lat, pulses);
      chk("edge_dx10_nohit", 32'(destroy[1]), 0);
      set_shot(1, 190, 450);
      watch(1, 12, lat, pulses);
      chk("edge_dxm10_nohit", 32'(destroy[1]), 0);
      set_shot(1, 200, 460);
      watch(1, 12, lat, pulses);
      chk("edge_y460_nohit", 32'(destroy[1]), 0);
      set_shot(1, 200, 439);
      watch(1, 12, lat, pulses);
      chk("edge_y439_nohit", 32'(destroy[1]), 0);
      set_shot(1, 209, 459);
      watch(1, 8, lat, pulses);
      chk("edge_209_459_hit", 32'(lat >= 1 && lat <= 6), 1);
      set_shot(1, 0, 0);
      @(negedge clk_4);
      chk("edge_clear1", 32'(destroy[1]), 0);

      // Remaining lives down to game over.
      wait_cooldown_end();
      chk("play_lives2", 32'(lives), 2);
      set_shot(3, 191, 440);
      watch(3, 8, lat, pulses);
      chk("hit3_pulses", 32'(pulses), 1);
      chk("hit3_lives", 32'(lives), 1);
      set_shot(3, 0, 0);
      wait_cooldown_end();
      set_shot(3, 200, 450);
      watch(3, 8, lat, pulses);
      chk("last_hit_lives", 32'(lives), 0);
      chk("last_hit_pulses", 32'(pulses), 1);
      chk("game_over_set", 32'(game_over), 1);
      chk("game_over_invuln", 32'(invuln), 0);
      set_shot(3, 0, 0);
      @(negedge clk_4);
      chk("go_pending_clear", 32'(destroy[3]), 0);
      set_shot(0, 200, 450);
      watch(0, 12, lat, pulses);
      chk("go_no_scan", 32'(destroy[0]), 0);
      chk("go_held", 32'(game_over), 1);
      set_shot(0, 0, 0);
      play = 1'b0;
      @(negedge clk_4);
      chk("idle_lives", 32'(lives), 3);
      chk("idle_game_over", 32'(game_over), 0);
      play = 1'b1;
      repeat (2) @(negedge clk_4);

      // New game: a hit costs a life again.
      set_shot(4, 200, 445);
      watch(4, 8, lat, pulses);
      chk("replay_lives", 32'(lives), 2);
      chk("replay_pulses", 32'(pulses), 1);

      // Async clear in the middle of cooldown.
      #2 clr = 1'b1;
      #1;
      chk("clr_lives", 32'(lives), 3);
      chk("clr_destroy", 32'(destroy), 0);
      chk("clr_invuln", 32'(invuln), 0);
      play = 1'b0;
      set_shot(4, 0, 0);
      @(negedge clk_4);
      clr = 1'b0;

`ifdef SHIELD_EN
      play = 1'b1;
      shield = 1'b1;
      repeat (2) @(negedge clk_4);
      set_shot(4, 200, 445);
      watch(4, 8, lat, pulses);
      chk("shield_destroy4", 32'(destroy[4]), 1);
      chk("shield_lives", 32'(lives), 3);
      chk("shield_pulses", 32'(pulses), 0);
      chk("shield_invuln", 32'(invuln), 0);
      chk("shield_game_over", 32'(game_over), 0);
      set_shot(4, 0, 0);
      @(negedge clk_4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
